// File: rtl/ustore_fetch_if.sv
// Handshake bundle between the uPC sequencer / microcode ROM side and the
// control-store fetch stage. The fetch stage uses the slave view.
interface ustore_fetch_if #(
  parameter int AW = 8,
  parameter int DW = 24,
  parameter int CW = 16
) ();
  logic          run;
  logic          step;
  logic [AW-1:0] upc_addr;
  logic          upc_req;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [DW-1:0] rom_data;
  logic          rom_ack;
  logic [DW-1:0] uword;
  logic          uword_valid;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] fetch_count;

  modport slave (
    input  run, step, upc_addr, upc_req, rom_data, rom_ack,
    output rom_addr, rom_rd, uword, uword_valid, busy, timeout_err, fetch_count
  );

  modport master (
    output run, step, upc_addr, upc_req, rom_data, rom_ack,
    input  rom_addr, rom_rd, uword, uword_valid, busy, timeout_err, fetch_count
  );
endinterface

// File: rtl/ustore_fetch.sv
// Control-store fetch stage: issues one microcode ROM read per request, waits
// for the acknowledge with a bounded timeout and presents the captured word.
module ustore_fetch #(
  parameter int AW      = 8,
  parameter int DW      = 24,
  parameter int TIMEOUT = 15,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  ustore_fetch_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_ERR     = 3'd4
  } state_e;

  localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_q;
  logic [AW-1:0] rom_addr_q;
  logic          rom_rd_q;
  logic [DW-1:0] uword_q;
  logic          uword_valid_q;
  logic          busy_q;
  logic          timeout_err_q;
  logic [CW-1:0] fetch_count_q;
  logic [CW-1:0] fetch_count_d;
  logic [7:0]    wait_cnt_q;
  logic [7:0]    wait_cnt_d;
  logic          go_s;
  logic          wait_last_s;

  // Start qualification and counter increments.
  always_comb begin
    go_s          = bus.upc_req & (bus.run | bus.step);
    wait_last_s   = (wait_cnt_q == WAIT_LAST);
    wait_cnt_d    = wait_cnt_q + 8'd1;
    fetch_count_d = fetch_count_q + CNT_ONE;
  end

  // Fetch sequencer; every output is registered on entry to the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= {AW{1'b0}};
      rom_rd_q      <= 1'b0;
      uword_q       <= {DW{1'b0}};
      uword_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      fetch_count_q <= {CW{1'b0}};
      wait_cnt_q    <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          uword_valid_q <= 1'b0;
          if (go_s) begin
            rom_addr_q <= bus.upc_addr;
            rom_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end else begin
            rom_rd_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end

        // An ack seen while the strobe is still up is too early and ignored.
        S_ISSUE: begin
          rom_rd_q   <= 1'b0;
          busy_q     <= 1'b1;
          wait_cnt_q <= 8'd0;
          state_q    <= S_WAIT;
        end

        S_WAIT: begin
          rom_rd_q <= 1'b0;
          if (bus.rom_ack) begin
            uword_q       <= bus.rom_data;
            uword_valid_q <= 1'b1;
            fetch_count_q <= fetch_count_d;
            state_q       <= S_PRESENT;
          end else if (wait_last_s) begin
            uword_q       <= {DW{1'b0}};
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_ERR;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end

        // Back-to-back issue straight from PRESENT keeps the 3-cycle cadence.
        S_PRESENT: begin
          uword_valid_q <= 1'b0;
          if (go_s) begin
            rom_addr_q <= bus.upc_addr;
            rom_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end else begin
            rom_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end

        S_ERR: begin
          rom_rd_q      <= 1'b0;
          uword_q       <= {DW{1'b0}};
          uword_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          timeout_err_q <= 1'b1;
          state_q       <= S_ERR;
        end

        default: begin
          rom_rd_q      <= 1'b0;
          uword_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.rom_rd      = rom_rd_q;
  assign bus.uword       = uword_q;
  assign bus.uword_valid = uword_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: doc/ustore_fetch.md
Name: ustore_fetch

Overview:
- Control-store fetch stage directly upstream of the microprogrammed CPU core.
- Takes the next micro-address from the uPC sequencer and issues a read to the 24-bit microcode ROM.
- Waits for the ROM acknowledge, then presents the captured microword to the core. `uword_valid` drives the core's "ROM word efficient" input.
- Adds run/single-step gating, a sticky timeout flag, and a fetch counter for the LED debug bus.

Parameters:
- AW, 8, control-store address width
- DW, 24, microword width
- TIMEOUT, 15, max WAIT cycles without `rom_ack` before error (1..255)
- CW, 16, `fetch_count` width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  free-run enable
- step  in  1  single-cycle pulse: one fetch when run=0
- upc_addr  in  AW  micro-address requested by sequencer
- upc_req  in  1  sequencer requests next microword
- rom_addr  out  AW  ROM address, held after issue
- rom_rd  out  1  ROM read strobe, one cycle per fetch
- rom_data  in  DW  ROM read data
- rom_ack  in  1  rom_data valid
- uword  out  DW  captured microword, held until next capture
- uword_valid  out  1  one-cycle pulse: uword newly valid
- busy  out  1  fetch in progress
- timeout_err  out  1  sticky timeout flag
- fetch_count  out  CW  completed-fetch counter

Behaviour:
- One clock `clk`. Reset is synchronous and active-high: `rst`=1 at a rising edge forces every register to its reset value, overriding all other inputs, including mid-fetch and in ERR.
- Reset values: rom_addr=0, rom_rd=0, uword=0, uword_valid=0, busy=0, timeout_err=0, fetch_count=0, state=IDLE, wait_cnt=0.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, ERR.
- Start condition `go` = upc_req & (run | step).
- IDLE: on `go` at an edge, latch upc_addr into rom_addr and enter ISSUE. Otherwise stay. Step pulses are ignored outside IDLE or PRESENT.
- ISSUE (exactly 1 cycle):
  - rom_rd=1, wait_cnt cleared, next state WAIT.
  - rom_ack during ISSUE is ignored.
- WAIT:
  - rom_rd=0; ack is sampled at each edge.
  - rom_ack=1: capture rom_data into uword, increment fetch_count (wraps all-ones to 0), go to PRESENT.
  - Else if wait_cnt==TIMEOUT-1: go to ERR.
  - Else wait_cnt+1.
  - Ack on the final counted cycle wins over timeout.
- PRESENT (exactly 1 cycle):
  - uword_valid=1.
  - On `go`: latch upc_addr and go to ISSUE (back-to-back, no IDLE bubble). Else go to IDLE.
- ERR:
  - timeout_err=1 (sticky), uword cleared to 0, uword_valid=0, rom_rd=0, busy=0.
  - Leaves only on rst.
- busy = 1 in ISSUE, WAIT, PRESENT; 0 in IDLE and ERR.
- Latency with an ack in the first WAIT cycle:
  - upc_req sampled at edge k.
  - rom_rd high in cycle k+1.
  - ack sampled at edge k+2.
  - uword_valid high in cycle k+2→k+3.
  - Peak throughput: 1 word / 3 cycles.
- run dropped mid-fetch: the current fetch completes normally; no new fetch starts.
- upc_addr changes after latch do not affect rom_addr until the next issue.
- uword holds its last captured value in IDLE/ISSUE/WAIT. The consumer must qualify it with uword_valid.
- rom_data is sampled only on the capture edge; X on rom_data at other times must not propagate.

Test Plan:
1. Reset then single fetch: run=1, upc_req=1, upc_addr=0x2A, ROM acks with 0xA5C3F0 one cycle after rom_rd → rom_rd pulses 1 cycle with rom_addr=0x2A; uword=0xA5C3F0; uword_valid high exactly 1 cycle; fetch_count=1.
2. Back-to-back: run=1, upc_req held high, addresses 0x00, 0x01, 0x02, immediate acks → three uword_valid pulses exactly 3 cycles apart, no IDLE cycle between them; fetch_count=3.
3. Single-step: run=0, upc_req=1, no step for 10 cycles → no rom_rd. One step pulse → exactly one fetch. A second step pulse during WAIT is ignored.
4. Slow ROM: ack after 14 WAIT cycles (TIMEOUT=15) → capture succeeds, timeout_err=0. Ack after 15 cycles → ERR, timeout_err=1, uword=0. The late ack is ignored; state holds until rst.
5. Reset mid-fetch: assert rst during WAIT, with an ack arriving in the same cycle → next cycle all outputs at reset values, no uword_valid pulse, fetch_count=0.
6. Counter wrap: preload via CW=4 build, 16 fetches → fetch_count goes 15→0; timeout_err clears only on rst.
